// File: rtl/key_pkg.sv
// Shared types and defaults for the key conditioning path.
// Latency: none (declarations only).
// Backpressure: none.
package key_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } key_state_t;

   localparam int TICK_DIV_DEF    = 100000;
   localparam int DEBOUNCE_MS_DEF = 20;

   // Counter width able to hold 0..n-1; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Key conditioning bundle: raw pin in, clean level/strobes/hold count out.
// Latency: none (wiring only).
// Backpressure: none; all outputs are unconditional strobes/levels.
interface key_debounce_if #(
   parameter int HOLD_W = 32
);
   logic              key_raw;
   logic              key_level;
   logic              press_pulse;
   logic              release_pulse;
   logic [HOLD_W-1:0] hold_ms;
   logic              tick_1ms;

   // Debouncer side: samples the pin, drives the conditioned outputs.
   modport master (
      input  key_raw,
      output key_level,
      output press_pulse,
      output release_pulse,
      output hold_ms,
      output tick_1ms
   );

   // Consumer side: owns the pin, reads the conditioned outputs.
   modport slave (
      output key_raw,
      input  key_level,
      input  press_pulse,
      input  release_pulse,
      input  hold_ms,
      input  tick_1ms
   );
endinterface

// File: rtl/ms_tick_gen.sv
// Free-running 1 ms time base: one-cycle tick every TICK_DIV clk cycles.
// Latency: tick is registered and aligned with counter = TICK_DIV-1.
// Backpressure: none; runs continuously, cleared only by rst.
module ms_tick_gen
   import key_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEF
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);
   localparam int CW = cnt_w(TICK_DIV);

   logic [CW-1:0] cnt;

   // Wrap counter; tick is pre-decoded one count early so it comes from a flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         if (cnt == CW'(TICK_DIV - 1)) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
         tick <= (cnt == CW'(TICK_DIV - 2));
      end
   end
endmodule

// File: rtl/key_debounce.sv
// Push-button conditioner: sync, tick-based debounce, press/release strobes, hold ms count.
// Latency: raw edge to strobe 2 + (DEBOUNCE_MS-1)*TICK_DIV + 1 .. 2 + DEBOUNCE_MS*TICK_DIV cycles.
// Backpressure: none; strobes are single-cycle and must be consumed when issued.
module key_debounce
   import key_pkg::*;
#(
   parameter int TICK_DIV    = TICK_DIV_DEF,
   parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF,
   parameter int HOLD_W      = 32
) (
   input  logic           clk,
   input  logic           rst,
   key_debounce_if.master bus
);
   localparam int                SW       = cnt_w(DEBOUNCE_MS);
   localparam logic [SW-1:0]     LAST_CNT = SW'(DEBOUNCE_MS - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = {HOLD_W{1'b1}};

   logic          sync_a;
   logic          key_sync;
   logic          tick;
   key_state_t    state;
   logic [SW-1:0] stable_cnt;

   // Shared time base; the same tick is exported for downstream timers.
   ms_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // Two-flop synchronizer for the asynchronous pin.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_a   <= 1'b0;
         key_sync <= 1'b0;
      end else begin
         sync_a   <= bus.key_raw;
         key_sync <= sync_a;
      end
   end

   // Debounce FSM with registered level, strobes and saturating hold counter.
   // A level change in a wait state wins over a tick arriving in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= IDLE;
         stable_cnt        <= '0;
         bus.key_level     <= 1'b0;
         bus.press_pulse   <= 1'b0;
         bus.release_pulse <= 1'b0;
         bus.hold_ms       <= '0;
      end else begin
         bus.press_pulse   <= 1'b0;
         bus.release_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (key_sync) begin
                  state      <= PRESS_WAIT;
                  stable_cnt <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!key_sync) begin
                  state <= IDLE;
               end else if (tick) begin
                  if (stable_cnt == LAST_CNT) begin
                     state           <= PRESSED;
                     bus.key_level   <= 1'b1;
                     bus.press_pulse <= 1'b1;
                     bus.hold_ms     <= '0;
                  end else begin
                     stable_cnt <= stable_cnt + 1'b1;
                  end
               end
            end
            PRESSED: begin
               if (!key_sync) begin
                  state      <= RELEASE_WAIT;
                  stable_cnt <= '0;
               end
               if (tick && bus.hold_ms != HOLD_MAX) begin
                  bus.hold_ms <= bus.hold_ms + 1'b1;
               end
            end
            RELEASE_WAIT: begin
               if (key_sync) begin
                  state <= PRESSED;
               end else if (tick) begin
                  if (stable_cnt == LAST_CNT) begin
                     state             <= IDLE;
                     bus.key_level     <= 1'b0;
                     bus.release_pulse <= 1'b1;
                  end else begin
                     stable_cnt <= stable_cnt + 1'b1;
                  end
               end
               // The release wait still belongs to the press, so it keeps counting.
               if (tick && bus.hold_ms != HOLD_MAX) begin
                  bus.hold_ms <= bus.hold_ms + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.tick_1ms = tick;
endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: stimulus queues expected strobes, a monitor checks them.
// Latency windows and hold counts are hand-derived for TICK_DIV=10, DEBOUNCE_MS=4.
// Backpressure: none exercised; the DUT has none.
module tb_key_debounce;
   localparam int TD = 10;
   localparam int DB = 4;

   typedef struct {
      bit     is_press;
      int     lo;
      int     hi;
      longint hold;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic key_raw;

   exp_t sb[$];
   exp_t e;
   int   checks    = 0;
   int   errors    = 0;
   int   cyc       = 0;
   int   last_tick = -1;
   int   n_press   = 0;
   int   n_rel     = 0;
   int   sat_rel   = 0;
   int   lvl_bad   = 0;
   bit   watch_lvl = 1'b0;
   logic watch_val = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   key_debounce_if #(.HOLD_W(32)) bus_main ();
   key_debounce_if #(.HOLD_W(4))  bus_sat ();

   assign bus_main.key_raw = key_raw;
   assign bus_sat.key_raw  = key_raw;

   key_debounce #(.TICK_DIV(TD), .DEBOUNCE_MS(DB), .HOLD_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_main)
   );

   key_debounce #(.TICK_DIV(TD), .DEBOUNCE_MS(DB), .HOLD_W(4)) dut_sat (
      .clk (clk),
      .rst (rst),
      .bus (bus_sat)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_range(input string name, input longint act, input longint lo, input longint hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: actual %0d required %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: pops the scoreboard on every strobe, checks tick period and level windows.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus_main.press_pulse || bus_main.release_pulse) begin
            chk("pulse_exclusive", longint'(bus_main.press_pulse && bus_main.release_pulse), 0);
            if (bus_main.press_pulse) n_press++;
            if (bus_main.release_pulse) n_rel++;
            chk("pulse_expected", longint'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("pulse_kind", longint'(bus_main.press_pulse), longint'(e.is_press));
               chk_range("pulse_latency", cyc, e.lo, e.hi);
               chk("hold_at_pulse", longint'(bus_main.hold_ms), e.hold);
               chk("level_at_pulse", longint'(bus_main.key_level), longint'(e.is_press));
            end
         end
         if (bus_main.tick_1ms) begin
            if (last_tick >= 0) chk("tick_period", cyc - last_tick, TD);
            last_tick = cyc;
         end
         if (bus_sat.release_pulse) sat_rel++;
         if (watch_lvl && bus_main.key_level !== watch_val) lvl_bad++;
      end else begin
         last_tick = -1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int q, f, a, np, nr, sr;
      int zero_main, zero_sat;

      // Reset with key held: everything zero while reset is applied.
      rst     = 1'b1;
      key_raw = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         zero_main = bus_main.key_level | bus_main.press_pulse | bus_main.release_pulse |
                     bus_main.tick_1ms | (|bus_main.hold_ms);
         zero_sat  = bus_sat.key_level | bus_sat.press_pulse | bus_sat.release_pulse |
                     bus_sat.tick_1ms | (|bus_sat.hold_ms);
         chk("reset_outputs_main", zero_main, 0);
         chk("reset_outputs_sat", zero_sat, 0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      q   = cyc;
      sb.push_back('{1'b1, q + 33, q + 43, 0});
      step(60);
      f       = cyc;
      key_raw = 1'b0;
      sb.push_back('{1'b0, f + 33, f + 43, 6});
      step(80);

      // Clean 200-cycle press: 20 ticks between acceptances.
      a       = cyc;
      key_raw = 1'b1;
      sb.push_back('{1'b1, a + 33, a + 43, 0});
      step(200);
      f       = cyc;
      key_raw = 1'b0;
      sb.push_back('{1'b0, f + 33, f + 43, 20});
      step(80);

      // Bounce: 7-cycle toggles never survive a full debounce window.
      np        = n_press;
      watch_val = 1'b0;
      watch_lvl = 1'b1;
      for (int i = 0; i < 60; i++) begin
         key_raw = ((i / 7) % 2 == 0);
         step(1);
      end
      key_raw = 1'b0;
      step(60);
      watch_lvl = 1'b0;
      chk("bounce_no_press", n_press - np, 0);
      chk("bounce_level_low", lvl_bad, 0);
      chk("bounce_hold_kept", longint'(bus_main.hold_ms), 20);

      // Release glitch of 15 cycles inside a 200-cycle press.
      a       = cyc;
      key_raw = 1'b1;
      sb.push_back('{1'b1, a + 33, a + 43, 0});
      step(100);
      nr        = n_rel;
      lvl_bad   = 0;
      watch_val = 1'b1;
      watch_lvl = 1'b1;
      key_raw   = 1'b0;
      step(15);
      key_raw = 1'b1;
      step(85);
      watch_lvl = 1'b0;
      chk("glitch_no_release", n_rel - nr, 0);
      chk("glitch_level_high", lvl_bad, 0);
      f       = cyc;
      key_raw = 1'b0;
      sb.push_back('{1'b0, f + 33, f + 43, 20});
      step(80);

      // Long press: 30 ticks, 4-bit counter saturates at 15.
      sr      = sat_rel;
      a       = cyc;
      key_raw = 1'b1;
      sb.push_back('{1'b1, a + 33, a + 43, 0});
      step(300);
      f       = cyc;
      key_raw = 1'b0;
      sb.push_back('{1'b0, f + 33, f + 43, 30});
      step(80);
      chk("sat_hold", longint'(bus_sat.hold_ms), 15);
      chk("sat_release_seen", sat_rel - sr, 1);

      // Reset in the middle of a press once hold_ms reaches 7.
      nr      = n_rel;
      a       = cyc;
      key_raw = 1'b1;
      sb.push_back('{1'b1, a + 33, a + 43, 0});
      for (int i = 0; i < 300 && !(bus_main.key_level && bus_main.hold_ms == 7); i++) begin
         @(negedge clk);
      end
      chk("midpress_hold_reached", longint'(bus_main.hold_ms), 7);
      rst = 1'b1;
      @(negedge clk);
      chk("midpress_level", longint'(bus_main.key_level), 0);
      chk("midpress_hold", longint'(bus_main.hold_ms), 0);
      chk("midpress_no_release", longint'(bus_main.release_pulse), 0);
      @(posedge clk);
      #1;
      rst     = 1'b0;
      key_raw = 1'b0;
      step(60);
      chk("midpress_no_release_after", n_rel - nr, 0);
      chk("scoreboard_drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/key_debounce.md
# key_debounce

Front-end conditioning stage for the single-key press-duration measurement path. It synchronizes the raw push-button input, rejects contact bounce using a 1 ms time base, and delivers a clean key level, single-cycle press/release strobes and a millisecond hold count. The downstream duration timer, display and lamp logic consume these outputs instead of sampling the pin directly.

## Interface
- `TICK_DIV`, 100000: `clk` cycles per 1 ms tick (100 MHz board clock). Must be ≥ 2.
- `DEBOUNCE_MS`, 20: consecutive stable ticks required to accept a level change. Must be ≥ 1.
- `HOLD_W`, 32: width of `hold_ms`.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `key_raw`  in  1  asynchronous button pin, 1 = pressed.
- `key_level`  out  1  debounced key state, 1 = pressed.
- `press_pulse`  out  1  one-cycle strobe on accepted press.
- `release_pulse`  out  1  one-cycle strobe on accepted release.
- `hold_ms`  out  HOLD_W  ms count of current or last press; saturating.
- `tick_1ms`  out  1  one-cycle strobe every TICK_DIV cycles.

## Operation
- **Synchronizer:** two flops, both reset to 0. `key_sync` is `key_raw` delayed by 2 cycles.
- **Tick generator:**
  - counter runs 0..TICK_DIV-1 and wraps.
  - `tick_1ms` is high in the cycle where counter = TICK_DIV-1.
  - free-running; cleared only by reset.
- **FSM states:** IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. `stable_cnt` is wide enough for DEBOUNCE_MS.
  - IDLE (`key_level`=0): `key_sync`=1 → PRESS_WAIT, `stable_cnt`←0.
  - PRESS_WAIT (`key_level`=0):
    - `key_sync`=0 → IDLE. This rejects the bounce.
    - else, on tick with `stable_cnt`=DEBOUNCE_MS-1 → PRESSED.
    - else, on tick, `stable_cnt`++.
  - PRESSED (`key_level`=1): `key_sync`=0 → RELEASE_WAIT, `stable_cnt`←0.
  - RELEASE_WAIT (`key_level`=1):
    - `key_sync`=1 → PRESSED. This rejects the glitch.
    - else, on tick with `stable_cnt`=DEBOUNCE_MS-1 → IDLE.
    - else, on tick, `stable_cnt`++.
- **Bounce check priority:** the bounce/glitch check has priority over the tick in the same cycle.
- **Strobes:** on the edge entering PRESSED from PRESS_WAIT, `press_pulse`=1 for exactly one cycle. On the edge entering IDLE from RELEASE_WAIT, `release_pulse`=1 for one cycle. Never both in the same cycle.
- **hold_ms:**
  - cleared to 0 on the edge entering PRESSED from PRESS_WAIT.
  - increments on each tick while in PRESSED or RELEASE_WAIT.
  - saturates at 2^HOLD_W-1.
  - frozen in IDLE and PRESS_WAIT, so it holds the last press duration until the next accepted press.
  - Press and release acceptance share the same debounce latency, so the bias cancels: `hold_ms` tracks the raw press duration to ±1 ms.

## Timing
- **Reset values:** all outputs 0, state IDLE, tick counter 0, `stable_cnt` 0, synchronizer flops 0.
- **Latency:** `key_raw` rising to `press_pulse` is 2 + (DEBOUNCE_MS-1)·TICK_DIV + 1 … 2 + DEBOUNCE_MS·TICK_DIV cycles, depending on tick phase. Release has the same latency.
- **Output registration:** all outputs come straight from flops; there is no combinational path from `key_raw`.
- **Reset mid-press:** `key_level` drops to 0 on the first reset edge, no `release_pulse` is issued, and `hold_ms`=0.
- **Key held through reset release:** IDLE→PRESS_WAIT, then a full debounce, then a normal `press_pulse`.
- **Tick coinciding with a state entry:** a tick in the cycle a wait state is entered is not counted. `stable_cnt` starts counting from the next tick.

## Structure
- **Package `key_pkg`:**
  - `key_state_t` enum (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT).
  - default constants `TICK_DIV_DEF`=100000 and `DEBOUNCE_MS_DEF`=20.
- **Sub-module `ms_tick_gen`:** parameter TICK_DIV; ports `clk`, `rst`, `tick`. It is reused by the downstream duration timer for a common time base.
- **Top:** synchronizer, FSM, `hold_ms` counter and strobe registers live in `key_debounce`.

## Test plan
Bench parameters: TICK_DIV=10, DEBOUNCE_MS=4, HOLD_W=32 unless stated.

1. **Reset with key held:** `key_raw`=1 during 3 cycles of `rst`, then release `rst`.
   - During reset: all outputs 0.
   - After reset: exactly one `press_pulse` within 33–43 cycles.
2. **Bounce rejection:** `key_raw` toggles every 7 cycles for 60 cycles, then settles at 0.
   - No `press_pulse`, `key_level` stays 0, `hold_ms` unchanged.
3. **Clean press:** `key_raw` high for 200 cycles, then low.
   - One `press_pulse`, one `release_pulse` about 200 cycles later, final `hold_ms`=20±1.
   - `tick_1ms` period is exactly 10 cycles throughout.
4. **Release glitch:** during a press, `key_raw` low for 15 cycles (<4 ticks).
   - No `release_pulse`, `key_level` stays 1, `hold_ms` continues incrementing.
5. **Saturation:** HOLD_W=4, press held 300 cycles.
   - `hold_ms` stops at 15, and `release_pulse` still fires.
6. **Reset mid-press:** assert `rst` while in PRESSED with `hold_ms`=7.
   - Next cycle: `key_level`=0, `hold_ms`=0, no `release_pulse`.
